// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: debug state encoding
// and the default watchdog limit.
package pipe_ctrl_pkg;

    // Debug view of which priority branch was taken in the previous cycle
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HAZ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_PEND = 2'd3
    } ctrl_state_e;

    localparam int TIMEOUT_CYC_DEF = 200;

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: counts consecutive frozen/stalled cycles, saturating at
// TIMEOUT_CYC, and raises a sticky timeout flag once the limit is reached.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TO_W        = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_stalled,
    output logic o_timeout
);

    localparam logic [TO_W-1:0] LP_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            r_timeout;

    // Next count: saturating increment while stalled, cleared otherwise
    always_comb begin
        w_cnt_nxt = '0;
        if (i_stalled) begin
            w_cnt_nxt = (r_to_cnt == LP_LIMIT) ? r_to_cnt : r_to_cnt + 1'b1;
        end
    end

    // Counter and sticky flag; the flag sets on the edge the count hits the limit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_cnt_nxt;
            r_timeout <= r_timeout | (w_cnt_nxt == LP_LIMIT);
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges hazard block requests, the memory hold
// and the ID-stage redirect into PC / IF/ID / ID/EX enables with zero latency.
// A redirect that arrives during a memory hold is parked until the hold drops.
// Optional stall-cycle perf counter enabled by defining STALL_PERF_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int TO_W        = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_req1,
    input  logic             stall_req2,
    input  logic             ext_hold,
    input  logic             redirect_req,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             pc_write_en,
    output logic             pc_sel_redirect,
    output logic [PC_W-1:0]  pc_target,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_bubble,
    output logic [1:0]       ctrl_state,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cycles,
    input  logic             perf_clear
);

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    logic            r_pend_valid;
    logic [PC_W-1:0] r_pend_pc;
    logic            w_hazard;
    logic            w_pend_set;
    logic            w_pend_clr;
    logic            w_stalled;

    assign w_hazard = stall_req1 | stall_req2;

    // Priority decode: reset, hold, hazard, parked redirect, live redirect, run
    always_comb begin
        pc_write_en     = 1'b1;
        pc_sel_redirect = 1'b0;
        pc_target       = redirect_pc;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_bubble    = 1'b0;
        w_state_nxt     = ST_RUN;
        w_pend_set      = 1'b0;
        w_pend_clr      = 1'b0;
        w_stalled       = 1'b0;
        if (reset) begin
            pc_write_en  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ext_hold) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_write_en = 1'b0;
            w_state_nxt    = ST_HOLD;
            w_stalled      = 1'b1;
            // Park the redirect only if its operands are valid and no slot is taken
            w_pend_set     = redirect_req & ~w_hazard & ~r_pend_valid;
        end else if (w_hazard) begin
            // Redirect ignored: branch operands are stale, it re-evaluates later
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            w_state_nxt    = ST_HAZ;
            w_stalled      = 1'b1;
        end else if (r_pend_valid) begin
            // Any live redirect this cycle is from the wrong path
            pc_sel_redirect = 1'b1;
            pc_target       = r_pend_pc;
            if_id_flush     = 1'b1;
            w_state_nxt     = ST_PEND;
            w_pend_clr      = 1'b1;
        end else if (redirect_req) begin
            pc_sel_redirect = 1'b1;
            if_id_flush     = 1'b1;
        end
    end

    // Debug state register: branch taken in the previous cycle
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    assign ctrl_state = r_state;

    // Parked redirect slot; reset discards anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else if (w_pend_set) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= redirect_pc;
        end else if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
        end
    end

    stall_watchdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clock     (clock),
        .reset     (reset),
        .i_stalled (w_stalled),
        .o_timeout (timeout)
    );

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;

    // Saturating stall-cycle counter; clear beats increment
    always_ff @(posedge clock) begin
        if (reset)                                 r_stall_cycles <= '0;
        else if (perf_clear)                       r_stall_cycles <= '0;
        else if (w_stalled && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign stall_cycles = r_stall_cycles;
`else
    logic w_unused_perf_clear;
    assign w_unused_perf_clear = perf_clear;
    assign stall_cycles        = '0;
`endif

endmodule
